// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed direct-form FIR: one multiply-accumulate per clock through an external adder.
// Each sample triggers TAPS MAC cycles, then the result is held until downstream accepts it.
module fir_mac_sequencer #(
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 8,
  parameter int unsigned N    = 16,
  parameter int unsigned TAPS = 8,
  parameter int unsigned AW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_wdata,
  output logic [N-1:0]  add_a,
  output logic [N-1:0]  add_b,
  output logic          add_cin,
  input  logic [N-1:0]  add_sum,
  input  logic          add_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          busy
);

  localparam int unsigned PW = DW + CW;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t               state;
  logic signed [DW-1:0] line [TAPS];
  logic signed [CW-1:0] coef [TAPS];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        base;
  logic [AW-1:0]        k;
  logic [N-1:0]         acc;

  logic [AW-1:0]        rd_idx;
  logic signed [PW-1:0] prod;
  logic [N-1:0]         prod_ext;
  logic                 in_mac;
  logic                 unused_cout;

  // Accumulation wraps mod 2^N, so the adder carry-out carries no information.
  assign unused_cout = add_cout;

  // Tap k reads the sample k steps older than the newest one (circular line).
  assign rd_idx   = base - k;
  assign prod     = line[rd_idx] * coef[k];
  assign prod_ext = N'(prod);
  assign in_mac   = (state == MAC);

  assign add_a    = in_mac ? acc : '0;
  assign add_b    = in_mac ? prod_ext : '0;
  assign add_cin  = 1'b0;
  assign in_ready = (state == IDLE);
  assign busy     = (state == MAC) || (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      line      <= '{default: '0};
      coef      <= '{default: '0};
      wr_ptr    <= '0;
      base      <= '0;
      k         <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A coefficient write on the accept edge is seen by that sample's MAC pass.
          if (coef_we) begin
            coef[coef_addr] <= $signed(coef_wdata);
          end
          if (in_valid) begin
            line[wr_ptr] <= $signed(in_data);
            base         <= wr_ptr;
            wr_ptr       <= wr_ptr + AW'(1);
            acc          <= '0;
            k            <= '0;
            state        <= MAC;
          end
        end
        MAC: begin
          acc <= add_sum;
          k   <= k + AW'(1);
          if (k == AW'(TAPS - 1)) begin
            out_data  <= add_sum;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: models the external adder and checks results against
// a direct convolution over a sample-history array.
module tb_fir_mac_sequencer;

  localparam int unsigned DW   = 8;
  localparam int unsigned CW   = 8;
  localparam int unsigned N    = 16;
  localparam int unsigned TAPS = 8;
  localparam int unsigned AW   = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_wdata;
  logic [N-1:0]  add_a;
  logic [N-1:0]  add_b;
  logic          add_cin;
  logic [N-1:0]  add_sum;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: h_m[k] coefficients, hist[j] = x[n-j].
  int           h_m  [TAPS];
  int           hist [TAPS];
  logic [N-1:0] exp_y;
  logic [N-1:0] got_y;

  fir_mac_sequencer #(.DW(DW), .CW(CW), .N(N), .TAPS(TAPS), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_wdata(coef_wdata),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Behavioural stand-in for the external carry-lookahead adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [N-1:0] model_y();
    int s = 0;
    for (int j = 0; j < int'(TAPS); j++) s += h_m[j] * hist[j];
    return N'(s);
  endfunction

  task automatic model_clear();
    for (int j = 0; j < int'(TAPS); j++) begin
      h_m[j]  = 0;
      hist[j] = 0;
    end
  endtask

  task automatic write_coef(input int addr, input int val);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = AW'(addr);
    coef_wdata = CW'(val);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    h_m[addr] = val;
  endtask

  // Present one sample (optionally with a simultaneous coefficient write) and wait for the accept edge.
  task automatic accept(input int x, input bit cw, input int ca, input int cd);
    int n = 0;
    @(negedge clk);
    in_valid   = 1'b1;
    in_data    = DW'(x);
    coef_we    = cw;
    coef_addr  = AW'(ca);
    coef_wdata = CW'(cd);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    if (cw) h_m[ca] = cd;
    for (int j = int'(TAPS) - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = x;
    exp_y = model_y();
  endtask

  // Wait for out_valid, check latency (negedges counted from the accept edge) and the result.
  task automatic collect(input string tag, input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk(tag, 32'(out_data), 32'(exp_y));
    got_y = out_data;
    if (out_ready) begin
      @(negedge clk);
      chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_idle"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    out_ready = 1'b1;
    model_clear();
    exp_y = '0;
    got_y = '0;

    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_add_b", 32'(add_b), 32'd0);
    chk("rst_add_cin", 32'(add_cin), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Impulse through h = 1..8
    for (int j = 0; j < int'(TAPS); j++) write_coef(j, j + 1);
    for (int j = 0; j < int'(TAPS); j++) begin
      accept((j == 0) ? 1 : 0, 1'b0, 0, 0);
      collect("impulse", 9);
      chk("impulse_const", 32'(got_y), 32'(j + 1));
    end

    // Wrap-around of the accumulator with all taps at 127
    for (int j = 0; j < int'(TAPS); j++) write_coef(j, 127);
    for (int j = 0; j < int'(TAPS); j++) begin
      accept(127, 1'b0, 0, 0);
      collect("wrap", 9);
      if (j == 3) chk("wrap_4th", 32'(got_y), 32'h0000FC04);
      if (j == 7) chk("wrap_8th", 32'(got_y), 32'h0000F808);
    end

    // Signed extremes
    for (int j = 1; j < int'(TAPS); j++) write_coef(j, 0);
    write_coef(0, -128);
    accept(-128, 1'b0, 0, 0);
    collect("sign_neg", 9);
    chk("sign_neg_const", 32'(got_y), 32'h00004000);
    accept(1, 1'b0, 0, 0);
    collect("sign_pos", 9);
    chk("sign_pos_const", 32'(got_y), 32'h0000FF80);

    // Back-pressure: result held, no new sample accepted while DONE
    out_ready = 1'b0;
    accept(37, 1'b0, 0, 0);
    collect("bp", 9);
    in_valid = 1'b1;
    in_data  = DW'(85);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold_data", 32'(out_data), 32'(exp_y));
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_no_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp_single_xfer", 32'(out_valid), 32'd0);
    chk("bp_no_accept", 32'(busy), 32'd0);

    // Coefficient write during MAC is dropped; in IDLE it applies
    accept(3, 1'b0, 0, 0);
    @(negedge clk);
    chk("mac_busy", 32'(busy), 32'd1);
    coef_we = 1'b1; coef_addr = '0; coef_wdata = CW'(5);
    @(negedge clk);
    coef_we = 1'b0;
    collect("coef_mac_ignored", 7);
    write_coef(0, 5);
    accept(4, 1'b0, 0, 0);
    collect("coef_idle_applied", 9);
    accept(-7, 1'b1, 1, 9);
    collect("coef_with_accept", 9);

    // Random coefficients and samples
    for (int j = 0; j < int'(TAPS); j++) write_coef(j, $signed(8'($urandom)));
    for (int s = 0; s < 16; s++) begin
      accept($signed(8'($urandom)), 1'b0, 0, 0);
      collect("random", 9);
    end

    // Reset in the middle of a MAC pass
    accept(100, 1'b0, 0, 0);
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    model_clear();
    exp_y = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < int'(TAPS); j++) begin
      accept((j == 0) ? 1 : 0, 1'b0, 0, 0);
      collect("post_reset", 9);
      chk("post_reset_zero", 32'(got_y), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
